// File: rtl/core_types_pkg.sv
// Shared core types: local-history geometry and the LHT update buffer entry.
package core_types_pkg;

  localparam int LH_LENGTH              = 8;
  localparam int ASID_WIDTH             = 9;
  localparam int LHT_UPDATER_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0]           full_PC;
    logic [ASID_WIDTH-1:0] ASID;
    logic [LH_LENGTH-1:0]  lh;
  } lht_update_entry_t;

endpackage

// File: rtl/lht_upd_youngest_match.sv
// Picks the youngest matching FIFO slot: walks the ring from head (oldest) forward so the last hit wins.
module lht_upd_youngest_match #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic [FIFO_DEPTH-1:0]         match_vec,
  input  logic [$clog2(FIFO_DEPTH)-1:0] head,
  output logic [FIFO_DEPTH-1:0]         youngest
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every output gets a default before any conditional write, otherwise a latch is inferred.
    youngest = '0;
    idx      = head;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (match_vec[idx]) begin
        youngest      = '0;
        youngest[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lht_updater.sv
// LHT write-side producer: buffers branch resolutions, chains same-branch histories, drives update0.
module lht_updater
  import core_types_pkg::*;
#(
  parameter int FIFO_DEPTH = LHT_UPDATER_FIFO_DEPTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  resolve_valid,
  output logic                  resolve_ready,
  input  logic [31:0]           resolve_full_PC,
  input  logic [ASID_WIDTH-1:0] resolve_ASID,
  input  logic [LH_LENGTH-1:0]  resolve_lh_snapshot,
  input  logic                  resolve_taken,
  input  logic                  update0_stall,
  output logic                  update0_valid,
  output logic [31:0]           update0_start_full_PC,
  output logic [ASID_WIDTH-1:0] update0_ASID,
  output logic [LH_LENGTH-1:0]  update0_lh
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lht_updater: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (LH_LENGTH < 2 || (LH_LENGTH % 8) != 0) begin : g_bad_lh
    $error("lht_updater: LH_LENGTH must be a multiple of 8");
  end

  lht_update_entry_t     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic                  last_wr_valid_q;
  logic [31:1]           last_wr_pc_q;
  logic [ASID_WIDTH-1:0] last_wr_asid_q;
  logic [LH_LENGTH-1:0]  last_wr_lh_q;

  logic                  not_empty, enq, deq;
  logic [FIFO_DEPTH-1:0] match_vec, youngest;
  logic [LH_LENGTH-1:0]  base, lh_new;
  lht_update_entry_t     head_entry;

  assign not_empty     = count_q != '0;
  assign resolve_ready = count_q != CNT_W'(FIFO_DEPTH);
  assign enq           = resolve_valid & resolve_ready;
  assign deq           = not_empty & ~update0_stall;

  // A slot is live when its distance from head is below count; the dequeuing head still counts.
  always_comb begin
    logic [PTR_W-1:0] age;
    match_vec = '0;
    age       = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      age = PTR_W'(i) - head_q;
      if (CNT_W'(age) < count_q &&
          fifo_q[i].full_PC[31:1] == resolve_full_PC[31:1] &&
          fifo_q[i].ASID == resolve_ASID)
        match_vec[i] = 1'b1;
    end
  end

  lht_upd_youngest_match #(.FIFO_DEPTH(FIFO_DEPTH)) u_youngest (
    .match_vec (match_vec),
    .head      (head_q),
    .youngest  (youngest)
  );

  always_comb begin
    logic [LH_LENGTH-1:0] fifo_base;
    fifo_base = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (youngest[i]) fifo_base = fifo_base | fifo_q[i].lh;
    // Last write covers the cycle where the LHT has not yet absorbed the previous update.
    if (|youngest)
      base = fifo_base;
    else if (last_wr_valid_q && last_wr_pc_q == resolve_full_PC[31:1] && last_wr_asid_q == resolve_ASID)
      base = last_wr_lh_q;
    else
      base = resolve_lh_snapshot;
  end

  assign lh_new = {base[LH_LENGTH-2:0], resolve_taken};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the payload array is not reset; count gates every read, so stale slots are never observed.
  always_ff @(posedge CLK) begin
    if (enq) fifo_q[tail_q] <= '{full_PC: resolve_full_PC, ASID: resolve_ASID, lh: lh_new};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_wr_valid_q <= 1'b0;
      last_wr_pc_q    <= '0;
      last_wr_asid_q  <= '0;
      last_wr_lh_q    <= '0;
    end else if (deq) begin
      last_wr_valid_q <= 1'b1;
      last_wr_pc_q    <= head_entry.full_PC[31:1];
      last_wr_asid_q  <= head_entry.ASID;
      last_wr_lh_q    <= head_entry.lh;
    end
  end

  assign head_entry            = fifo_q[head_q];
  assign update0_valid         = deq;
  assign update0_start_full_PC = not_empty ? head_entry.full_PC : '0;
  assign update0_ASID          = not_empty ? head_entry.ASID    : '0;
  assign update0_lh            = not_empty ? head_entry.lh      : '0;

endmodule
